// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Owns the program counter, drives the instruction-memory byte address and
// latches the returned word into the IF/ID register. Handles stall,
// branch redirect with flush, end-of-program halt and misaligned-target trap.
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [ADDR_W-1:0] PC_LIMIT = 8'h70,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] inst_address,
  input  logic [31:0]       instruction,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic              halted,
  output logic              trap,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [31:0]       NOP     = 32'h00000013;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              valid_n;
  logic [31:0]       instr_n;
  logic [ADDR_W-1:0] ipc_n;
  logic [ADDR_W-1:0] ipc4_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              target_aligned;

  assign inst_address   = pc;
  assign halted         = (state == HALT);
  assign trap           = (state == TRAP);
  assign target_aligned = (branch_target[1:0] == 2'b00);

  // Next-state and next-register values; branch beats stall, stall beats fetch
  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = if_id_valid;
    instr_n = if_id_instr;
    ipc_n   = if_id_pc;
    ipc4_n  = if_id_pc4;
    cnt_n   = fetch_count;
    case (state)
      RUN: begin
        if (branch_taken) begin
          valid_n = 1'b0;
          if (target_aligned) begin
            pc_n    = branch_target;
            instr_n = NOP;
          end else begin
            state_n = TRAP;
          end
        end else if (!stall) begin
          instr_n = instruction;
          ipc_n   = pc;
          ipc4_n  = pc + PC_STEP;
          valid_n = 1'b1;
          cnt_n   = fetch_count + CNT_W'(1);
          if (pc == PC_LIMIT) begin
            state_n = HALT;
          end else begin
            pc_n = pc + PC_STEP;
          end
        end
      end
      HALT: begin
        if (branch_taken) begin
          valid_n = 1'b0;
          if (target_aligned) begin
            pc_n    = branch_target;
            instr_n = NOP;
            state_n = RUN;
          end else begin
            state_n = TRAP;
          end
        end else if (!stall) begin
          valid_n = 1'b0;
        end
      end
      TRAP: begin
        valid_n = 1'b0;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  // State, PC, IF/ID and counter registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP;
      if_id_pc    <= '0;
      if_id_pc4   <= '0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      if_id_valid <= valid_n;
      if_id_instr <= instr_n;
      if_id_pc    <= ipc_n;
      if_id_pc4   <= ipc4_n;
      fetch_count <= cnt_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// Two instances (default limits, and a reset/limit at 0xFC) share stimulus;
// a behavioural model of the fetch rules is compared every negative edge.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;

  logic [7:0]  a_inst_address, b_inst_address;
  logic [31:0] a_instruction, b_instruction;
  logic        a_valid, b_valid;
  logic [31:0] a_instr, b_instr;
  logic [7:0]  a_pc, b_pc;
  logic [7:0]  a_pc4, b_pc4;
  logic        a_halted, b_halted;
  logic        a_trap, b_trap;
  logic [15:0] a_count, b_count;

  logic [31:0] mem [64];

  int compared   = 0;
  int mismatched = 0;
  bit checking_on = 0;

  // Abstract fetch-stage view: mode 0 = fetching, 1 = halted, 2 = trapped
  typedef struct packed {
    logic [7:0]  pc;
    logic [1:0]  mode;
    logic        valid;
    logic [31:0] instr;
    logic [7:0]  ipc;
    logic [7:0]  ipc4;
    logic [15:0] cnt;
  } model_t;

  model_t ma, mb;

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .PC_LIMIT(8'h70), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .inst_address(a_inst_address),
    .instruction(a_instruction), .if_id_valid(a_valid), .if_id_instr(a_instr),
    .if_id_pc(a_pc), .if_id_pc4(a_pc4), .halted(a_halted), .trap(a_trap),
    .fetch_count(a_count)
  );

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFC), .PC_LIMIT(8'hFC), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .inst_address(b_inst_address),
    .instruction(b_instruction), .if_id_valid(b_valid), .if_id_instr(b_instr),
    .if_id_pc(b_pc), .if_id_pc4(b_pc4), .halted(b_halted), .trap(b_trap),
    .fetch_count(b_count)
  );

  assign a_instruction = mem[a_inst_address[7:2]];
  assign b_instruction = mem[b_inst_address[7:2]];

  // Free-running clock, period 10
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic model_t reset_model(logic [7:0] start_pc);
    model_t r;
    r.pc    = start_pc;
    r.mode  = 2'd0;
    r.valid = 1'b0;
    r.instr = NOP;
    r.ipc   = 8'h00;
    r.ipc4  = 8'h00;
    r.cnt   = 16'd0;
    return r;
  endfunction

  // One clock of the fetch rules applied to the abstract view
  function automatic model_t step(model_t s, logic stl, logic br, logic [7:0] tgt,
                                  logic [7:0] lim);
    model_t r;
    bit misaligned;
    r = s;
    misaligned = (tgt % 4) != 0;
    if (s.mode == 2'd2) begin
      r.valid = 1'b0;
    end else if (br) begin
      r.valid = 1'b0;
      if (misaligned) begin
        r.mode = 2'd2;
      end else begin
        r.pc    = tgt;
        r.instr = NOP;
        r.mode  = 2'd0;
      end
    end else if (stl) begin
      r = s;
    end else if (s.mode == 2'd1) begin
      r.valid = 1'b0;
    end else begin
      r.instr = mem[s.pc / 4];
      r.ipc   = s.pc;
      r.ipc4  = 8'((int'(s.pc) + 4) % 256);
      r.valid = 1'b1;
      r.cnt   = 16'((int'(s.cnt) + 1) % 65536);
      if (s.pc == lim) r.mode = 2'd1;
      else r.pc = 8'((int'(s.pc) + 4) % 256);
    end
    return r;
  endfunction

  // Reference model advances on the same edges as the design
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma <= reset_model(8'h00);
      mb <= reset_model(8'hFC);
    end else begin
      ma <= step(ma, stall, branch_taken, branch_target, 8'h70);
      mb <= step(mb, stall, branch_taken, branch_target, 8'hFC);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      if (mismatched <= 40)
        $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Every negative edge, all outputs of both instances against the model
  always @(negedge clk) begin
    if (checking_on) begin
      checkOutput("a_inst_address", 32'(a_inst_address), 32'(ma.pc));
      checkOutput("a_valid",        32'(a_valid),        32'(ma.valid));
      checkOutput("a_instr",        a_instr,             ma.instr);
      checkOutput("a_pc",           32'(a_pc),           32'(ma.ipc));
      checkOutput("a_pc4",          32'(a_pc4),          32'(ma.ipc4));
      checkOutput("a_halted",       32'(a_halted),       32'(ma.mode == 2'd1));
      checkOutput("a_trap",         32'(a_trap),         32'(ma.mode == 2'd2));
      checkOutput("a_count",        32'(a_count),        32'(ma.cnt));
      checkOutput("b_inst_address", 32'(b_inst_address), 32'(mb.pc));
      checkOutput("b_valid",        32'(b_valid),        32'(mb.valid));
      checkOutput("b_instr",        b_instr,             mb.instr);
      checkOutput("b_pc",           32'(b_pc),           32'(mb.ipc));
      checkOutput("b_pc4",          32'(b_pc4),          32'(mb.ipc4));
      checkOutput("b_halted",       32'(b_halted),       32'(mb.mode == 2'd1));
      checkOutput("b_trap",         32'(b_trap),         32'(mb.mode == 2'd2));
      checkOutput("b_count",        32'(b_count),        32'(mb.cnt));
    end
  end

  task automatic applyStimulus(input logic stl, input logic br, input logic [7:0] tgt);
    stall         = stl;
    branch_taken  = br;
    branch_target = tgt;
    @(negedge clk);
  endtask

  task automatic applyReset();
    stall = 0; branch_taken = 0; branch_target = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    bit saw_halt;
    reset = 0; stall = 0; branch_taken = 0; branch_target = 0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h00a00093;
    mem[1] = 32'h01400113;
    #1 reset = 1;
    @(negedge clk);
    reset = 0;
    checking_on = 1;

    // Reset values
    checkOutput("rst_valid", 32'(a_valid), 32'd0);
    checkOutput("rst_instr", a_instr, NOP);
    checkOutput("rst_addr_a", 32'(a_inst_address), 32'h00);
    checkOutput("rst_addr_b", 32'(b_inst_address), 32'hFC);
    checkOutput("rst_count", 32'(a_count), 32'd0);

    // First two fetches
    applyStimulus(0, 0, 8'h00);
    checkOutput("f1_instr", a_instr, 32'h00a00093);
    checkOutput("f1_pc", 32'(a_pc), 32'h00);
    checkOutput("f1_pc4", 32'(a_pc4), 32'h04);
    checkOutput("f1_valid", 32'(a_valid), 32'd1);
    checkOutput("b_halt_fc", 32'(b_halted), 32'd1);
    checkOutput("b_addr_fc", 32'(b_inst_address), 32'hFC);
    checkOutput("b_pc4_wrap", 32'(b_pc4), 32'h00);
    applyStimulus(0, 0, 8'h00);
    checkOutput("f2_instr", a_instr, 32'h01400113);
    checkOutput("f2_pc", 32'(a_pc), 32'h04);
    checkOutput("f2_count", 32'(a_count), 32'd2);

    // Stall three cycles at 0x08
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 8'h00);
    checkOutput("stall_addr", 32'(a_inst_address), 32'h08);
    checkOutput("stall_pc", 32'(a_pc), 32'h04);
    checkOutput("stall_count", 32'(a_count), 32'd2);
    applyStimulus(0, 0, 8'h00);
    checkOutput("unstall_pc", 32'(a_pc), 32'h08);
    checkOutput("unstall_instr", a_instr, mem[2]);
    applyStimulus(0, 0, 8'h00);
    checkOutput("pre_br_addr", 32'(a_inst_address), 32'h10);

    // Branch wins over stall
    applyStimulus(1, 1, 8'h40);
    checkOutput("br_addr", 32'(a_inst_address), 32'h40);
    checkOutput("br_valid", 32'(a_valid), 32'd0);
    checkOutput("br_count", 32'(a_count), 32'd4);
    applyStimulus(0, 0, 8'h00);
    checkOutput("br_pc", 32'(a_pc), 32'h40);
    checkOutput("br_valid2", 32'(a_valid), 32'd1);

    // Free run to the halt at 0x70
    applyReset();
    saw_halt = 0;
    for (int i = 0; i < 100 && !saw_halt; i++) begin
      applyStimulus(0, 0, 8'h00);
      saw_halt = a_halted;
    end
    if (!saw_halt) begin
      compared++; mismatched++;
      $display("[TB] FAIL halt_timeout: got no halt, expected halt within 100 cycles");
    end
    checkOutput("run_count", 32'(a_count), 32'd29);
    checkOutput("run_addr", 32'(a_inst_address), 32'h70);
    checkOutput("run_lastpc", 32'(a_pc), 32'h70);
    applyStimulus(0, 0, 8'h00);
    checkOutput("halt_valid", 32'(a_valid), 32'd0);
    checkOutput("halt_still", 32'(a_halted), 32'd1);
    applyStimulus(0, 1, 8'h00);
    checkOutput("resume_halted", 32'(a_halted), 32'd0);
    checkOutput("resume_addr", 32'(a_inst_address), 32'h00);
    applyStimulus(0, 0, 8'h00);
    checkOutput("resume_valid", 32'(a_valid), 32'd1);

    // Misaligned target traps; later branches and stall are ignored
    applyStimulus(0, 1, 8'h06);
    checkOutput("trap_set", 32'(a_trap), 32'd1);
    checkOutput("trap_valid", 32'(a_valid), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 8'h20);
    checkOutput("trap_hold_addr", 32'(a_inst_address), 32'h04);
    checkOutput("trap_hold", 32'(a_trap), 32'd1);
    applyReset();
    checkOutput("trap_clear", 32'(a_trap), 32'd0);
    checkOutput("trap_rst_addr", 32'(a_inst_address), 32'h00);

    // Asynchronous reset between clock edges at PC 0x24
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 8'h00);
    checkOutput("async_pre_addr", 32'(a_inst_address), 32'h24);
    #2 reset = 1;
    #1;
    checkOutput("async_addr", 32'(a_inst_address), 32'h00);
    checkOutput("async_valid", 32'(a_valid), 32'd0);
    checkOutput("async_instr", a_instr, NOP);
    checkOutput("async_count", 32'(a_count), 32'd0);
    @(negedge clk);
    reset = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] tgt;
      tgt = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      reset = ($urandom_range(0, 99) < 2);
      applyStimulus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10, tgt);
    end
    reset = 0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
